// File: rtl/wb_cmd_master_if.sv
// Command, response and Wishbone signals of wb_cmd_master.
// master: the bus master's view; slave: the environment's view.
interface wb_cmd_master_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = DATA_WIDTH / 8
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_we_i;
    logic [ADDR_WIDTH-1:0] cmd_adr_i;
    logic [DATA_WIDTH-1:0] cmd_dat_i;
    logic [SEL_WIDTH-1:0]  cmd_sel_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_dat_o;
    logic                  rsp_err_o;
    logic                  rsp_tmo_o;

    logic                  cyc_o;
    logic                  stb_o;
    logic                  we_o;
    logic [ADDR_WIDTH-1:0] adr_o;
    logic [DATA_WIDTH-1:0] dat_o;
    logic [SEL_WIDTH-1:0]  sel_o;
    logic [DATA_WIDTH-1:0] dat_i;
    logic                  ack_i;
    logic                  err_i;
    logic                  stall_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  rsp_ready_i, dat_i, ack_i, err_i, stall_i,
        output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_tmo_o,
        output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output rsp_ready_i, dat_i, ack_i, err_i, stall_i,
        input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_tmo_o,
        input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Pipelined Wishbone B4 master: command stream in, bus cycles out,
// one in-order response per command through a small response FIFO.
module wb_cmd_master #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int GRANULE    = 8,
    parameter int RSP_DEPTH  = 4,
    parameter int TIMEOUT    = 256
) (
    input logic             clk_i,
    input logic             rst_i,
    wb_cmd_master_if.master bus
);
    localparam int SEL_WIDTH = DATA_WIDTH / GRANULE;
    localparam int PW        = $clog2(RSP_DEPTH);
    localparam int CW        = PW + 1;
    localparam int TW        = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        FLUSH
    } state_e;

    state_e                state_q, state_d;
    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic [CW-1:0]         out_q, out_d;
    logic [TW-1:0]         tmr_q, tmr_d;

    logic [RSP_DEPTH-1:0]  owe_q, owe_d;
    logic [PW-1:0]         owr_q, owr_d;
    logic [PW-1:0]         ord_q, ord_d;

    logic [DATA_WIDTH-1:0] mdat_q [RSP_DEPTH];
    logic [DATA_WIDTH-1:0] mdat_d [RSP_DEPTH];
    logic [RSP_DEPTH-1:0]  merr_q, merr_d;
    logic [RSP_DEPTH-1:0]  mtmo_q, mtmo_d;
    logic [PW-1:0]         wr_q, wr_d;
    logic [PW-1:0]         rd_q, rd_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic                  ready;
    logic                  accept;
    logic                  issue;
    logic                  retire;
    logic                  pop;
    logic                  tmo_hit;
    logic                  rsp_valid;
    logic [CW:0]           inflight;
    logic                  push;
    logic                  push_err;
    logic                  push_tmo;
    logic [DATA_WIDTH-1:0] push_dat;

    // Every accepted command holds a FIFO slot until its response is popped.
    assign inflight = {1'b0, out_q} + {{CW{1'b0}}, stb_q} + {1'b0, cnt_q};
    assign ready    = ~rst_i & (state_q != FLUSH)
                    & (~stb_q | ~bus.stall_i)
                    & (inflight < (CW+1)'(RSP_DEPTH));
    assign accept   = bus.cmd_valid_i & ready;
    assign issue    = stb_q & ~bus.stall_i;
    assign retire   = (state_q == BUS) & (out_q != '0)
                    & (bus.ack_i | bus.err_i);
    assign rsp_valid = cnt_q != '0;
    assign pop      = rsp_valid & bus.rsp_ready_i;
    assign tmo_hit  = (state_q == BUS) & (out_q != '0)
                    & ~issue & ~retire
                    & (tmr_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        stb_d    = stb_q;
        we_d     = we_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        out_d    = out_q;
        tmr_d    = '0;
        owe_d    = owe_q;
        owr_d    = owr_q;
        ord_d    = ord_q;
        push     = 1'b0;
        push_err = 1'b0;
        push_tmo = 1'b0;
        push_dat = '0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUS;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = bus.cmd_we_i;
                    adr_d   = bus.cmd_adr_i;
                    dat_d   = bus.cmd_dat_i;
                    sel_d   = bus.cmd_sel_i;
                end
            end
            BUS: begin
                if (retire) begin
                    push     = 1'b1;
                    push_err = bus.err_i;
                    push_dat = (bus.err_i | owe_q[ord_q]) ? '0 : bus.dat_i;
                    ord_d    = ord_q + PW'(1);
                end
                if (issue) begin
                    owe_d[owr_q] = we_q;
                    owr_d        = owr_q + PW'(1);
                    stb_d        = 1'b0;
                end
                if (accept) begin
                    stb_d = 1'b1;
                    we_d  = bus.cmd_we_i;
                    adr_d = bus.cmd_adr_i;
                    dat_d = bus.cmd_dat_i;
                    sel_d = bus.cmd_sel_i;
                end
                out_d = out_q + CW'(issue) - CW'(retire);
                if (!issue && !retire && out_q != '0) begin
                    tmr_d = tmr_q + TW'(1);
                end
                // Abort: pending strobe and a same-cycle accept also get error responses.
                if (tmo_hit) begin
                    state_d = FLUSH;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    out_d   = out_q + CW'(stb_q) + CW'(accept);
                    tmr_d   = '0;
                    owr_d   = '0;
                    ord_d   = '0;
                end else if (!stb_d && out_d == '0) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                end
            end
            FLUSH: begin
                push     = 1'b1;
                push_err = 1'b1;
                push_tmo = 1'b1;
                out_d    = out_q - CW'(1);
                if (out_q == CW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        mdat_d = mdat_q;
        merr_d = merr_q;
        mtmo_d = mtmo_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        if (push) begin
            mdat_d[wr_q] = push_dat;
            merr_d[wr_q] = push_err;
            mtmo_d[wr_q] = push_tmo;
            wr_d         = wr_q + PW'(1);
        end
        if (pop) begin
            rd_d = rd_q + PW'(1);
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            out_q   <= '0;
            tmr_q   <= '0;
            owe_q   <= '0;
            owr_q   <= '0;
            ord_q   <= '0;
            mdat_q  <= '{default: '0};
            merr_q  <= '0;
            mtmo_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            out_q   <= out_d;
            tmr_q   <= tmr_d;
            owe_q   <= owe_d;
            owr_q   <= owr_d;
            ord_q   <= ord_d;
            mdat_q  <= mdat_d;
            merr_q  <= merr_d;
            mtmo_q  <= mtmo_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.cmd_ready_o = ready;
    assign bus.cyc_o       = cyc_q;
    assign bus.stb_o       = stb_q;
    assign bus.we_o        = we_q;
    assign bus.adr_o       = adr_q;
    assign bus.dat_o       = dat_q;
    assign bus.sel_o       = sel_q;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_dat_o   = rsp_valid ? mdat_q[rd_q] : '0;
    assign bus.rsp_err_o   = rsp_valid & merr_q[rd_q];
    assign bus.rsp_tmo_o   = rsp_valid & mtmo_q[rd_q];
endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomized and directed checks of wb_cmd_master against a
// queue-level model of commands, bus transfers and responses.
module tb_wb_cmd_master;
    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int SW   = 4;
    localparam int DEP  = 4;
    localparam int TMO  = 32;
    localparam int NREG = 16;

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
    } cmd_t;

    typedef struct {
        logic          we;
        logic          err;
        logic [DW-1:0] rd;
    } xfer_t;

    typedef struct {
        logic [DW-1:0] dat;
        logic          err;
        logic          tmo;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) bus ();

    wb_cmd_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8),
        .RSP_DEPTH(DEP), .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.master)
    );

    // model state
    cmd_t          pend[$];
    xfer_t         outq[$];
    rsp_t          rspq[$];
    int            flushcnt = 0;
    int            tcnt = 0;
    logic [DW-1:0] smem [NREG];

    // stimulus controls
    logic cv = 1'b0;
    logic rr = 1'b1;
    cmd_t c;
    int   st_prob = 0, ack_prob = 100, spur_prob = 0;
    bit   noack = 1'b0;
    int   st_from = -1, st_to = -1;

    // observation
    int   checks = 0, errors = 0;
    int   cyc_n = 0;
    bit   last_acc;
    rsp_t log_q[$];
    int   n_acc = 0;
    int   cyc_rise = 0;
    logic cyc_prev = 1'b0;
    int   last_iss = 0;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h cycle %0d", nm, got, exp, cyc_n);
        end
    endtask

    function automatic int inflight();
        return pend.size() + outq.size() + rspq.size() + flushcnt;
    endfunction

    function automatic bit model_empty();
        return pend.size() == 0 && outq.size() == 0 && rspq.size() == 0 && flushcnt == 0;
    endfunction

    task automatic model_reset();
        pend.delete();
        outq.delete();
        rspq.delete();
        flushcnt = 0;
        tcnt = 0;
    endtask

    task automatic cycle();
        logic          stl, a, e, exp_rdy, iss, ret, pop, abort;
        logic [DW-1:0] di;
        xfer_t         x;
        cmd_t          p;
        @(negedge clk);
        cyc_n++;
        stl = (cyc_n >= st_from && cyc_n <= st_to) ? 1'b1
            : ($urandom_range(99) < st_prob);
        a  = 1'b0;
        e  = 1'b0;
        di = $urandom;
        if (outq.size() > 0 && !noack && $urandom_range(99) < ack_prob) begin
            if (outq[0].err) begin
                e = 1'b1;
                a = 1'($urandom_range(1));
            end else begin
                a = 1'b1;
                if (!outq[0].we) di = outq[0].rd;
            end
        end else if (outq.size() == 0 && $urandom_range(99) < spur_prob) begin
            a = 1'b1;
        end
        bus.stall_i     = stl;
        bus.ack_i       = a;
        bus.err_i       = e;
        bus.dat_i       = di;
        bus.cmd_valid_i = cv;
        bus.cmd_we_i    = c.we;
        bus.cmd_adr_i   = c.adr;
        bus.cmd_dat_i   = c.dat;
        bus.cmd_sel_i   = c.sel;
        bus.rsp_ready_i = rr;
        #1;
        exp_rdy = !rst && flushcnt == 0 && (pend.size() == 0 || !stl) && inflight() < DEP;
        chk("cmd_ready", bus.cmd_ready_o, exp_rdy);
        chk("cyc", bus.cyc_o, pend.size() > 0 || outq.size() > 0);
        chk("stb", bus.stb_o, pend.size() > 0);
        if (pend.size() > 0) begin
            chk("we", bus.we_o, pend[0].we);
            chk("adr", bus.adr_o, pend[0].adr);
            chk("dat", bus.dat_o, pend[0].dat);
            chk("sel", bus.sel_o, pend[0].sel);
        end
        chk("rsp_valid", bus.rsp_valid_o, rspq.size() > 0);
        if (rspq.size() > 0) begin
            chk("rsp_dat", bus.rsp_dat_o, rspq[0].dat);
            chk("rsp_err", bus.rsp_err_o, rspq[0].err);
            chk("rsp_tmo", bus.rsp_tmo_o, rspq[0].tmo);
        end
        if (bus.cyc_o && !cyc_prev) cyc_rise++;
        cyc_prev = bus.cyc_o;
        if (bus.stb_o && !stl) last_iss = cyc_n;
        if (bus.rsp_valid_o && rr)
            log_q.push_back('{dat: bus.rsp_dat_o, err: bus.rsp_err_o, tmo: bus.rsp_tmo_o});
        if (cv && bus.cmd_ready_o) n_acc++;
        last_acc = cv && exp_rdy;
        if (rst) return;
        iss   = pend.size() > 0 && !stl;
        ret   = flushcnt == 0 && outq.size() > 0 && (a || e);
        pop   = rspq.size() > 0 && rr;
        abort = 1'b0;
        if (pop) void'(rspq.pop_front());
        if (flushcnt == 0 && outq.size() > 0 && !iss && !ret) begin
            if (tcnt + 1 == TMO) abort = 1'b1;
            else tcnt++;
        end else begin
            tcnt = 0;
        end
        if (flushcnt > 0) begin
            rspq.push_back('{dat: '0, err: 1'b1, tmo: 1'b1});
            flushcnt--;
        end else if (abort) begin
            flushcnt = outq.size() + pend.size() + (last_acc ? 1 : 0);
            outq.delete();
            pend.delete();
            tcnt = 0;
        end else begin
            if (ret) begin
                x = outq.pop_front();
                rspq.push_back('{dat: (e || x.we) ? '0 : di, err: e, tmo: 1'b0});
            end
            if (iss) begin
                p = pend.pop_front();
                x.we  = p.we;
                x.err = p.adr >= NREG;
                x.rd  = '0;
                if (!x.err) begin
                    if (p.we) begin
                        for (int i = 0; i < SW; i++)
                            if (p.sel[i]) smem[p.adr][8*i +: 8] = p.dat[8*i +: 8];
                    end else begin
                        x.rd = smem[p.adr];
                    end
                end
                outq.push_back(x);
            end
            if (last_acc) pend.push_back(c);
        end
    endtask

    task automatic send(input cmd_t x);
        int n = 0;
        cv = 1'b1;
        c  = x;
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 200);
        cv = 1'b0;
        checks++;
        if (!last_acc) begin
            errors++;
            $display("FAIL send_timeout got none expected accept cycle %0d", cyc_n);
        end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        cv = 1'b0;
        while (!model_empty() && n < bound) begin
            cycle();
            n++;
        end
        checks++;
        if (!model_empty()) begin
            errors++;
            $display("FAIL drain_timeout got busy expected idle cycle %0d", cyc_n);
        end
        cycle();
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog got stuck expected finish");
        $fatal(1);
    end

    initial begin
        int drop;
        for (int i = 0; i < NREG; i++) smem[i] = '0;
        c = '{we: 1'b0, adr: '0, dat: '0, sel: '0};
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_adr_i   = '0;
        bus.cmd_dat_i   = '0;
        bus.cmd_sel_i   = '0;
        bus.rsp_ready_i = 1'b0;
        bus.dat_i       = '0;
        bus.ack_i       = 1'b0;
        bus.err_i       = 1'b0;
        bus.stall_i     = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_cmd_ready", bus.cmd_ready_o, 0);
        chk("rst_cyc", bus.cyc_o, 0);
        chk("rst_stb", bus.stb_o, 0);
        chk("rst_we", bus.we_o, 0);
        chk("rst_adr", bus.adr_o, 0);
        chk("rst_dat", bus.dat_o, 0);
        chk("rst_sel", bus.sel_o, 0);
        chk("rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("rst_rsp_dat", bus.rsp_dat_o, 0);
        chk("rst_rsp_err", bus.rsp_err_o, 0);
        chk("rst_rsp_tmo", bus.rsp_tmo_o, 0);
        rst = 1'b0;

        // write then read back
        log_q.delete();
        send('{we: 1'b1, adr: 16'h0003, dat: 32'hDEADBEEF, sel: 4'hF});
        send('{we: 1'b0, adr: 16'h0003, dat: 32'h0, sel: 4'hF});
        drain(100);
        chk("t1_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("t1_wr_dat", log_q[0].dat, 32'h0);
            chk("t1_wr_err", log_q[0].err, 0);
            chk("t1_rd_dat", log_q[1].dat, 32'hDEADBEEF);
            chk("t1_rd_err", log_q[1].err, 0);
        end

        // burst of writes with a stall pulse
        log_q.delete();
        cyc_rise = 0;
        st_from = cyc_n + 3;
        st_to   = cyc_n + 4;
        for (int i = 0; i < 4; i++)
            send('{we: 1'b1, adr: 16'(4 + i), dat: 32'hC0DE0000 + i, sel: 4'hF});
        drain(100);
        st_from = -1;
        st_to   = -1;
        chk("t2_envelopes", cyc_rise, 1);
        chk("t2_count", log_q.size(), 4);
        if (log_q.size() == 4) chk("t2_last_err", log_q[3].err, 0);

        // out-of-map read then normal traffic
        log_q.delete();
        send('{we: 1'b0, adr: 16'h0040, dat: 32'h0, sel: 4'hF});
        send('{we: 1'b1, adr: 16'h0002, dat: 32'h12345678, sel: 4'hF});
        send('{we: 1'b0, adr: 16'h0002, dat: 32'h0, sel: 4'hF});
        drain(100);
        chk("t3_count", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("t3_err", log_q[0].err, 1);
            chk("t3_err_dat", log_q[0].dat, 0);
            chk("t3_next_dat", log_q[2].dat, 32'h12345678);
            chk("t3_next_err", log_q[2].err, 0);
        end

        // response back-pressure limits commands in flight
        rr = 1'b0;
        n_acc = 0;
        cv = 1'b1;
        for (int i = 0; i < 20 && n_acc < 6; i++) begin
            c = '{we: 1'b1, adr: 16'(8 + (i % 4)), dat: $urandom, sel: 4'hF};
            cycle();
        end
        cv = 1'b0;
        chk("t4_accepted", n_acc, DEP);
        chk("t4_ready_held", bus.cmd_ready_o, 0);
        rr = 1'b1;
        drain(100);

        // no acks: timeout abort
        log_q.delete();
        noack = 1'b1;
        send('{we: 1'b0, adr: 16'h0005, dat: 32'h0, sel: 4'hF});
        send('{we: 1'b0, adr: 16'h0006, dat: 32'h0, sel: 4'hF});
        drop = 0;
        for (int i = 0; i < TMO + 20 && drop == 0; i++) begin
            cycle();
            if (!bus.cyc_o) drop = cyc_n;
        end
        chk("t5_abort_delay", drop - last_iss, TMO + 1);
        noack = 1'b0;
        drain(100);
        chk("t5_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("t5_err0", log_q[0].err, 1);
            chk("t5_tmo0", log_q[0].tmo, 1);
            chk("t5_err1", log_q[1].err, 1);
            chk("t5_tmo1", log_q[1].tmo, 1);
        end

        // reset with transfers outstanding
        noack = 1'b1;
        send('{we: 1'b0, adr: 16'h0001, dat: 32'h0, sel: 4'hF});
        send('{we: 1'b0, adr: 16'h0002, dat: 32'h0, sel: 4'hF});
        cycle();
        cycle();
        chk("t6_pre_cyc", bus.cyc_o, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_cyc", bus.cyc_o, 0);
        chk("t6_stb", bus.stb_o, 0);
        chk("t6_rsp_valid", bus.rsp_valid_o, 0);
        chk("t6_ready", bus.cmd_ready_o, 0);
        model_reset();
        noack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc_prev = 1'b0;
        log_q.delete();
        send('{we: 1'b1, adr: 16'h0001, dat: 32'hA5A50001, sel: 4'hF});
        send('{we: 1'b0, adr: 16'h0001, dat: 32'h0, sel: 4'hF});
        drain(100);
        chk("t6_count", log_q.size(), 2);
        if (log_q.size() == 2) chk("t6_rd_dat", log_q[1].dat, 32'hA5A50001);

        // randomized traffic
        st_prob   = 25;
        ack_prob  = 50;
        spur_prob = 3;
        for (int i = 0; i < 3000; i++) begin
            noack = (i % 600) >= 500;
            cv = 1'($urandom_range(1));
            c  = '{we: 1'($urandom_range(1)), adr: 16'($urandom_range(19)),
                   dat: $urandom, sel: 4'($urandom_range(15))};
            rr = $urandom_range(99) < 70;
            cycle();
        end
        noack = 1'b0;
        rr = 1'b1;
        st_prob = 0;
        spur_prob = 0;
        drain(500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
